// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryptor: one cipher round per clock with the round key
// generated on the fly. S-boxes are computed as GF(2^8) inverse plus affine map.
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] result
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv, sq;

   // x^254 = x^-1 (and 0 maps to 0), built from the squares x^2..x^128
   always_comb begin
      inv = 8'h01;
      sq  = data;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
   end

   assign result = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module subBytes #(
   parameter int NUM_LANES = 16
) (
   input  logic [NUM_LANES-1:0][7:0] data,
   output logic [NUM_LANES-1:0][7:0] result
);
   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         aes_sbox u_sbox (.data(data[g]), .result(result[g]));
      end
   endgenerate
endmodule

module aes128_enc_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic [127:0] ciphertext
);
   typedef enum logic {IDLE, ROUND} fsm_t;

   fsm_t         fsm;
   logic [3:0]   r;
   logic [7:0]   rcon;
   logic [127:0] state, rkey;
   logic [127:0] sb, sr, mc, nk, ns;
   logic [31:0]  rot, sw, nw0, nw1, nw2, nw3;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Key schedule: SubWord(RotWord(w3)) ^ rcon folded into w0, then chained
   assign rot = {rkey[23:0], rkey[31:24]};
   subBytes #(.NUM_LANES(4)) u_subword (.data(rot), .result(sw));
   assign nw0 = rkey[127:96] ^ sw ^ {rcon, 24'h0};
   assign nw1 = rkey[95:64] ^ nw0;
   assign nw2 = rkey[63:32] ^ nw1;
   assign nw3 = rkey[31:0] ^ nw2;
   assign nk  = {nw0, nw1, nw2, nw3};

   subBytes #(.NUM_LANES(16)) u_subbytes (.data(state), .result(sb));

   // Byte i = row (i%4), column (i/4); row k rotates left by k columns
   genvar c, rw;
   generate
      for (c = 0; c < 4; c++) begin : g_col
         for (rw = 0; rw < 4; rw++) begin : g_row
            assign sr[127-8*(4*c+rw) -: 8] = sb[127-8*(4*((c+rw)%4)+rw) -: 8];
         end
         assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
      end
   endgenerate

   assign ns = ((r == 4'd10) ? sr : mc) ^ nk;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         r          <= '0;
         rcon       <= '0;
         state      <= '0;
         rkey       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ciphertext <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: if (start) begin
               state <= plaintext ^ key;
               rkey  <= key;
               r     <= 4'd1;
               rcon  <= 8'h01;
               busy  <= 1'b1;
               fsm   <= ROUND;
            end
            ROUND: begin
               state <= ns;
               rkey  <= nk;
               rcon  <= xtime(rcon);
               if (r == 4'd10) begin
                  ciphertext <= ns;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  r          <= '0;
                  fsm        <= IDLE;
               end else begin
                  r <= r + 4'd1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule
